// File: rtl/fifo_wptr_full.sv
// rtl/fifo_wptr_full.sv - async FIFO write-side pointer, Gray publish and full/level/overflow status
// Optional almost-full comparator: define FIFO_WPTR_AFULL_EN to build it; otherwise O_AFULL is tied low.
module fifo_wptr_full #(
  parameter int AW       = 4,
  parameter int AFULL_TH = 12
) (
  input  logic          I_CLK,
  input  logic          I_RST_N,
  input  logic          I_WR_EN,
  input  logic [AW:0]   I_RPTR_GRAY_SYNC,
  output logic          O_WEN,
  output logic [AW-1:0] O_WADDR,
  output logic [AW:0]   O_WPTR_GRAY,
  output logic          O_FULL,
  output logic [AW:0]   O_WLEVEL,
  output logic          O_AFULL,
  output logic          O_OVF
);

  if (AW < 2) begin : g_aw_chk
    $error("fifo_wptr_full: AW must be at least 2");
  end
  if ((AFULL_TH < 1) || (AFULL_TH > (1 << AW))) begin : g_th_chk
    $error("fifo_wptr_full: AFULL_TH must lie in 1..2^AW");
  end

  logic [AW:0] wbin;
  logic [AW:0] wbin_next;
  logic [AW:0] wgray_next;
  logic [AW:0] rbin;
  logic [AW:0] rgray_full;
  logic [AW:0] level_next;
  logic        full_next;

  // A write while full is dropped, so the pointer only moves on O_WEN.
  assign O_WEN      = I_WR_EN & ~O_FULL;
  assign wbin_next  = wbin + {{AW{1'b0}}, O_WEN};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  always_comb begin
    rbin = '0;
    for (int i = 0; i <= AW; i++) begin
      rbin[i] = ^(I_RPTR_GRAY_SYNC >> i);
    end
  end

  // Full when the write pointer sits one lap ahead: top two Gray bits inverted.
  assign rgray_full = {~I_RPTR_GRAY_SYNC[AW:AW-1], I_RPTR_GRAY_SYNC[AW-2:0]};
  assign full_next  = (wgray_next == rgray_full);
  assign level_next = wbin_next - rbin;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      wbin        <= '0;
      O_WPTR_GRAY <= '0;
      O_FULL      <= 1'b0;
      O_WLEVEL    <= '0;
      O_OVF       <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      O_WPTR_GRAY <= wgray_next;
      O_FULL      <= full_next;
      O_WLEVEL    <= level_next;
      O_OVF       <= O_OVF | (I_WR_EN & O_FULL);
    end
  end

  assign O_WADDR = wbin[AW-1:0];

`ifdef FIFO_WPTR_AFULL_EN
  localparam logic [AW:0] AFULL_TH_V = (AW+1)'(AFULL_TH);

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      O_AFULL <= 1'b0;
    end else begin
      O_AFULL <= (level_next >= AFULL_TH_V);
    end
  end
`else
  assign O_AFULL = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb/tb_fifo_wptr_full.sv - self-checking bench for fifo_wptr_full against a counter-based model
module tb_fifo_wptr_full;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;
  localparam int TH    = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [4:0] rg;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wgray;
  logic       full;
  logic [4:0] wlevel;
  logic       afull;
  logic       ovf;

  fifo_wptr_full #(.AW(AW), .AFULL_TH(TH)) dut (
    .I_CLK(clk), .I_RST_N(rst_n), .I_WR_EN(wr_en), .I_RPTR_GRAY_SYNC(rg),
    .O_WEN(wen), .O_WADDR(waddr), .O_WPTR_GRAY(wgray), .O_FULL(full),
    .O_WLEVEL(wlevel), .O_AFULL(afull), .O_OVF(ovf)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   m_w, m_r, m_level;
  logic m_full, m_ovf, m_afull;
  logic exp_wen, obs_wen;

  // Model: absolute counts of accepted writes and of the read position.
  function automatic logic [4:0] gray_of(input int b);
    int         v;
    logic [4:0] x;
    v = b & (PMOD - 1);
    x = 5'(v);
    return x ^ (x >> 1);
  endfunction

  function automatic logic afull_rule(input int level);
`ifdef FIFO_WPTR_AFULL_EN
    return (level >= TH);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_w = 0; m_r = 0; m_level = 0;
    m_full = 1'b0; m_ovf = 1'b0; m_afull = 1'b0;
  endtask

  task automatic do_reset();
    wr_en = 1'b0; rg = '0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic wr, input int rp);
    wr_en = wr;
    rg    = gray_of(rp);
    m_r   = rp;
    #1;
    obs_wen = wen;
    exp_wen = wr && !m_full;
    @(posedge clk); #1;
    m_ovf   = m_ovf | (wr & m_full);
    if (exp_wen) m_w++;
    m_level = ((m_w - m_r) % PMOD + PMOD) % PMOD;
    m_full  = (m_level == DEPTH);
    m_afull = afull_rule(m_level);
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0; wr_en = 1'b1; rg = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (wen !== 1'b1) begin bad++; $display("FAIL rst_wen got=%0h exp=1", wen); end
    total++; if ({waddr, wgray, full, wlevel, afull, ovf} !== '0) begin
      bad++; $display("FAIL rst_outputs got=%0h exp=0", {waddr, wgray, full, wlevel, afull, ovf});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 0);
    total++; if (waddr !== 4'd5) begin bad++; $display("FAIL pre_rst_addr got=%0d exp=5", waddr); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({waddr, wgray, full, wlevel, afull, ovf} !== '0) begin
      bad++; $display("FAIL async_rst got=%0h exp=0", {waddr, wgray, full, wlevel, afull, ovf});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 0);
    total++; if (obs_wen !== 1'b1) begin bad++; $display("FAIL post_rst_wen got=%0h exp=1", obs_wen); end
    total++; if (waddr !== 4'd1) begin bad++; $display("FAIL post_rst_addr got=%0d exp=1", waddr); end
  endtask

  task automatic test_fill();
    do_reset();
    total++; if (waddr !== 4'd0) begin bad++; $display("FAIL fill_first_addr got=%0d exp=0", waddr); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 0);
      total++; if (waddr !== 4'(m_w % DEPTH) || wlevel !== 5'(m_level) || full !== m_full) begin
        bad++; $display("FAIL fill_step%0d got=addr%0d lvl%0d full%0b exp=addr%0d lvl%0d full%0b",
                        i, waddr, wlevel, full, m_w % DEPTH, m_level, m_full);
      end
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%0b exp=1", full); end
    total++; if (wlevel !== 5'd16) begin bad++; $display("FAIL fill_level got=%0d exp=16", wlevel); end
    total++; if (wgray !== 5'b11000) begin bad++; $display("FAIL fill_gray got=%b exp=11000", wgray); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 0);
      total++; if (obs_wen !== 1'b0) begin bad++; $display("FAIL ovf_wen got=%0b exp=0", obs_wen); end
      total++; if (waddr !== 4'd0) begin bad++; $display("FAIL ovf_addr got=%0d exp=0", waddr); end
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", ovf); end
    end
    step(1'b0, 0);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", ovf); end
  endtask

  task automatic test_drain();
    step(1'b0, 2);
    total++; if (full !== 1'b0) begin bad++; $display("FAIL drain_full got=%0b exp=0", full); end
    total++; if (wlevel !== 5'd14) begin bad++; $display("FAIL drain_level got=%0d exp=14", wlevel); end
    step(1'b1, 2);
    total++; if (wlevel !== 5'd15) begin bad++; $display("FAIL drain_write_level got=%0d exp=15", wlevel); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL drain_ovf got=%0b exp=1", ovf); end
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    do_reset();
    prev = wgray;
    for (int i = 0; i < 64; i++) begin
      step(1'b1, m_w - 1);
      total++; if (wgray !== gray_of(m_w) || $countones(prev ^ wgray) != 1) begin
        bad++; $display("FAIL wrap_gray%0d got=%b prev=%b exp=%b", i, wgray, prev, gray_of(m_w));
      end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL wrap_full%0d got=%0b exp=0", i, full); end
      prev = wgray;
    end
  endtask

  task automatic test_afull();
    do_reset();
    for (int i = 1; i <= TH; i++) begin
      step(1'b1, 0);
      total++; if (afull !== afull_rule(i)) begin
        bad++; $display("FAIL afull_w%0d got=%0b exp=%0b", i, afull, afull_rule(i));
      end
    end
  endtask

  task automatic test_random();
    int rp;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rp = m_r;
      if ($urandom_range(0, 3) == 0) rp = m_r + int'($urandom_range(0, m_w - m_r));
      step(1'($urandom_range(0, 1)), rp);
      total++; if (obs_wen !== exp_wen) begin bad++; $display("FAIL rnd_wen%0d got=%0b exp=%0b", i, obs_wen, exp_wen); end
      total++; if (waddr !== 4'(m_w % DEPTH) || wgray !== gray_of(m_w)) begin
        bad++; $display("FAIL rnd_ptr%0d got=addr%0d gray%b exp=addr%0d gray%b", i, waddr, wgray, m_w % DEPTH, gray_of(m_w));
      end
      total++; if (full !== m_full || wlevel !== 5'(m_level) || afull !== m_afull || ovf !== m_ovf) begin
        bad++; $display("FAIL rnd_status%0d got=f%0b l%0d a%0b o%0b exp=f%0b l%0d a%0b o%0b",
                        i, full, wlevel, afull, ovf, m_full, m_level, m_afull, m_ovf);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rg = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_afull();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_wptr_full.md
# fifo_wptr_full

Write-domain pointer and status generator for the asynchronous FIFO. It accepts write requests, advances a binary write pointer, and drives the RAM write address and write enable. It publishes a registered Gray-coded write pointer for the read-domain two-flop synchronizer. It consumes the read pointer, Gray-coded and already synchronized into this domain, to produce full, fill level, almost-full and sticky overflow status.

## Interface
Parameters:
- AW, 4: address width; FIFO depth = 2^AW; AW >= 2.
- AFULL_TH, 12: almost-full threshold in entries; 1 <= AFULL_TH <= 2^AW.

Ports:
- I_CLK  in  1  write-domain clock; the only clock in the block.
- I_RST_N  in  1  reset, asynchronous assert, active-low.
- I_WR_EN  in  1  write request from producer.
- I_RPTR_GRAY_SYNC  in  AW+1  read pointer, Gray-coded, already synchronized to I_CLK.
- O_WEN  out  1  RAM write enable = I_WR_EN & ~O_FULL (combinational).
- O_WADDR  out  AW  RAM write address = wbin[AW-1:0] (register output).
- O_WPTR_GRAY  out  AW+1  registered Gray write pointer, for the read-domain synchronizer.
- O_FULL  out  1  FIFO full, registered.
- O_WLEVEL  out  AW+1  conservative fill level, registered.
- O_AFULL  out  1  O_WLEVEL >= AFULL_TH, registered (see Configuration).
- O_OVF  out  1  sticky overflow flag.

## Operation
- One clock (I_CLK); reset is asynchronous and active-low (I_RST_N).
- Internal wbin, AW+1 bits. wbin_next = wbin + O_WEN, with modulo 2^(AW+1) wrap.
- wgray_next = (wbin_next >> 1) ^ wbin_next. O_WPTR_GRAY <= wgray_next.
- The read pointer is decoded to binary: rbin = gray2bin(I_RPTR_GRAY_SYNC), an XOR prefix from the MSB down.
- Full is computed on next state: O_FULL <= (wgray_next == {~rgray[AW:AW-1], rgray[AW-2:0]}), where rgray = I_RPTR_GRAY_SYNC.
- Level: O_WLEVEL <= (wbin_next - rbin) mod 2^(AW+1); range 0..2^AW.
- Overflow: O_OVF <= O_OVF | (I_WR_EN & O_FULL). It clears only on reset.
- A write while full is dropped: pointers are unchanged and O_WEN = 0.
- Status is pessimistic. The read pointer arrives late, so full and level may overstate occupancy and never understate it.

## Timing
- Reset values: wbin = 0, O_WADDR = 0, O_WPTR_GRAY = 0, O_FULL = 0, O_WLEVEL = 0, O_AFULL = 0, O_OVF = 0. O_WEN follows I_WR_EN during reset; the RAM must be held by reset.
- Accepted write at edge N:
  - RAM writes at O_WADDR during cycle N.
  - O_WADDR, O_WPTR_GRAY, O_FULL, O_WLEVEL and O_AFULL all update at edge N+1, with 1-cycle latency.
- O_WPTR_GRAY changes by exactly one bit per accepted write, including the 2^(AW+1)-1 -> 0 wrap. It is driven straight from a flop with no combinational logic between register and output.
- A change on I_RPTR_GRAY_SYNC updates O_FULL, O_WLEVEL and O_AFULL one edge later.
- A simultaneous write and read-pointer advance uses both new values in the same next-state computation. There is no priority issue.
- Reset asserted mid-operation clears all state immediately; the next write after release goes to address 0.

## Configuration
- Macro: FIFO_WPTR_AFULL_EN.
- Defined: the almost-full comparator is built; O_AFULL <= (level_next >= AFULL_TH).
- Undefined: the comparator and its flop are omitted; O_AFULL is tied to 0. O_WLEVEL is always built.

## Test plan
- Reset: assert I_RST_N = 0 mid-stream with I_WR_EN = 1 -> all outputs reset immediately. After release, the first write has O_WADDR = 0.
- Fill (AW = 4): I_RPTR_GRAY_SYNC = 0, 16 consecutive writes -> O_FULL = 1 after the 16th edge, O_WLEVEL = 16, O_WPTR_GRAY = 5'b11000.
- Overflow: while full, I_WR_EN = 1 for 3 cycles -> O_WEN = 0, O_WADDR stays 0, O_OVF = 1 and stays 1 after I_WR_EN drops.
- Drain: from full, set I_RPTR_GRAY_SYNC = 5'b00011 (binary 2) -> one edge later O_FULL = 0 and O_WLEVEL = 14. The next write gives O_WLEVEL = 15.
- Wrap: 64 writes with the read pointer tracking wbin - 1 -> O_WPTR_GRAY has Hamming distance 1 on every change, including 31 -> 0, and O_FULL never asserts.
- Almost-full (macro defined, AFULL_TH = 12): 11 writes -> O_AFULL = 0; 12th write -> O_AFULL = 1 one edge later. With the macro undefined, O_AFULL stays 0 throughout.
